cpu_run_ctrl: RTL

//  Sequences the debug-controlled CPU clock. Accepts STEP/RUN commands from the debug command

---
 rtl/cpu_run_ctrl_pkg.sv | 22 ++
 rtl/cpu_run_bp_cmp.sv | 43 ++++
 rtl/cpu_run_ctrl.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/cpu_run_ctrl_pkg.sv
// Shared definitions for the debug-controlled CPU clock sequencer:
// command opcodes, stop codes and the run-control state encoding.
package cpu_run_ctrl_pkg;

  localparam logic RC_OP_STEP = 1'b0;
  localparam logic RC_OP_RUN  = 1'b1;

  typedef enum logic [1:0] {
    RC_STOP_NONE = 2'd0,
    RC_STOP_CNT  = 2'd1,
    RC_STOP_BP   = 2'd2,
    RC_STOP_HALT = 2'd3
  } rc_stop_e;

  typedef enum logic [1:0] {
    RC_ST_IDLE = 2'd0,
    RC_ST_LOW  = 2'd1,
    RC_ST_HIGH = 2'd2,
    RC_ST_FIN  = 2'd3
  } rc_state_e;

endpackage

// File: rtl/cpu_run_bp_cmp.sv
// PC breakpoint register bank with write port and combinational hit compare.
// Writes to an index at or beyond NUM_BP are dropped; the compare always
// sees the register contents from before a same-cycle write.
module cpu_run_bp_cmp #(
  parameter int NUM_BP = 4
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        bp_we,
  input  logic [2:0]  bp_idx,
  input  logic [31:0] bp_addr,
  input  logic        bp_en,
  input  logic [31:0] pc_chk,
  output logic        bp_hit
);

  logic [31:0]       addr_q [NUM_BP];
  logic [NUM_BP-1:0] en_q;

  // Breakpoint registers; only slots that exist can match bp_idx.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < NUM_BP; i++) addr_q[i] <= '0;
      en_q <= '0;
    end else begin
      for (int i = 0; i < NUM_BP; i++) begin
        if (bp_we && (bp_idx == 3'(i))) begin
          addr_q[i] <= bp_addr;
          en_q[i]   <= bp_en;
        end
      end
    end
  end

  // Any enabled slot matching the current PC raises a hit.
  always_comb begin
    bp_hit = 1'b0;
    for (int i = 0; i < NUM_BP; i++) begin
      if (en_q[i] && (addr_q[i] == pc_chk)) bp_hit = 1'b1;
    end
  end

endmodule

// File: rtl/cpu_run_ctrl.sv
// Debug CPU clock sequencer: emits clk_cpu pulses for STEP (N pulses) or RUN
// (until breakpoint or halt). clk_cpu is a register, so it is glitch-free and
// each phase lasts exactly HALF_PER clk cycles.
//
//  state | meaning
//  IDLE  | waiting for a command, clk_cpu low, cmd_rdy high
//  LOW   | clk_cpu low phase; stop conditions evaluated on its last cycle
//  HIGH  | clk_cpu high phase; STEP count consumed on its last cycle
//  FIN   | one-cycle completion, done high, stop_code valid
module cpu_run_ctrl
  import cpu_run_ctrl_pkg::*;
#(
  parameter int NUM_BP   = 4,
  parameter int CNT_W    = 16,
  parameter int HALF_PER = 2
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             cmd_vld,
  output logic             cmd_rdy,
  input  logic             cmd_op,
  input  logic [CNT_W-1:0] cmd_cnt,
  input  logic             halt_req,
  input  logic             bp_we,
  input  logic [2:0]       bp_idx,
  input  logic [31:0]      bp_addr,
  input  logic             bp_en,
  input  logic [31:0]      pc_chk,
  output logic             clk_cpu,
  output logic             busy,
  output logic             done,
  output logic [1:0]       stop_code,
  output logic [31:0]      cyc_run
);

  localparam int              HP_W    = (HALF_PER > 1) ? $clog2(HALF_PER) : 1;
  localparam logic [HP_W-1:0] HP_LOAD = HP_W'(HALF_PER - 1);

  rc_state_e        state;
  logic [HP_W-1:0]  hp_cnt;
  logic [CNT_W-1:0] remain;
  logic             op_run;
  logic             first;
  logic             halt_lat;
  logic             clk_cpu_q;
  logic             done_q;
  rc_stop_e         stop_q;
  logic [31:0]      cyc_q;
  logic             bp_hit;
  logic             hp_last;

  cpu_run_bp_cmp #(.NUM_BP(NUM_BP)) u_bp_cmp (
    .clk     (clk),
    .rstn    (rstn),
    .bp_we   (bp_we),
    .bp_idx  (bp_idx),
    .bp_addr (bp_addr),
    .bp_en   (bp_en),
    .pc_chk  (pc_chk),
    .bp_hit  (bp_hit)
  );

  assign hp_last   = (hp_cnt == '0);
  assign cmd_rdy   = (state == RC_ST_IDLE);
  assign busy      = (state != RC_ST_IDLE);
  assign clk_cpu   = clk_cpu_q;
  assign done      = done_q;
  assign stop_code = stop_q;
  assign cyc_run   = cyc_q;

  // Run-control FSM with half-period down-counter, step counter and edge count.
  // A halt latched late in a phase is acted on at the end of the next LOW
  // phase, so a high pulse is never cut short.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= RC_ST_IDLE;
      hp_cnt    <= '0;
      remain    <= '0;
      op_run    <= 1'b0;
      first     <= 1'b0;
      halt_lat  <= 1'b0;
      clk_cpu_q <= 1'b0;
      done_q    <= 1'b0;
      stop_q    <= RC_STOP_NONE;
      cyc_q     <= '0;
    end else begin
      done_q <= 1'b0;
      case (state)
        RC_ST_IDLE: begin
          if (cmd_vld) begin
            state    <= RC_ST_LOW;
            hp_cnt   <= HP_LOAD;
            remain   <= (cmd_cnt == '0) ? CNT_W'(1) : cmd_cnt;
            op_run   <= (cmd_op == RC_OP_RUN);
            first    <= 1'b1;
            halt_lat <= 1'b0;
            cyc_q    <= '0;
            stop_q   <= RC_STOP_NONE;
          end
        end
        RC_ST_LOW: begin
          if (halt_req) halt_lat <= 1'b1;
          if (!hp_last) begin
            hp_cnt <= hp_cnt - HP_W'(1);
          end else if (halt_lat) begin
            state    <= RC_ST_FIN;
            stop_q   <= RC_STOP_HALT;
            done_q   <= 1'b1;
            halt_lat <= 1'b0;
          end else if (op_run && !first && bp_hit) begin
            state    <= RC_ST_FIN;
            stop_q   <= RC_STOP_BP;
            done_q   <= 1'b1;
            halt_lat <= 1'b0;
          end else begin
            state     <= RC_ST_HIGH;
            hp_cnt    <= HP_LOAD;
            first     <= 1'b0;
            clk_cpu_q <= 1'b1;
            cyc_q     <= cyc_q + 32'd1;
          end
        end
        RC_ST_HIGH: begin
          if (halt_req) halt_lat <= 1'b1;
          if (!hp_last) begin
            hp_cnt <= hp_cnt - HP_W'(1);
          end else begin
            clk_cpu_q <= 1'b0;
            hp_cnt    <= HP_LOAD;
            if (!op_run) remain <= remain - CNT_W'(1);
            if (!op_run && (remain == CNT_W'(1))) begin
              state    <= RC_ST_FIN;
              stop_q   <= RC_STOP_CNT;
              done_q   <= 1'b1;
              halt_lat <= 1'b0;
            end else begin
              state <= RC_ST_LOW;
            end
          end
        end
        RC_ST_FIN: begin
          state <= RC_ST_IDLE;
        end
        default: begin
          state <= RC_ST_IDLE;
        end
      endcase
    end
  end

endmodule
